hssl_rx_frame_decoder: RTL and testbench

- Receive-side framing decoder for the HSSL link. Sits between the GT receiver outputs (rx_usrclk2 domain) and the SpiNNaker packet path.
- Classifies 32-bit 8b/10b words, acquires and monitors link sync from idle words, and strips SOF/EOF framing.
- Emits payload words with last/error markers. This is the counterpart of the transmit-side framer that drives tx_data/tx_charisk.

---
 rtl/hssl_rx_frame_decoder.sv | 231 +++++++++++++++++++++++
 tb/tb_hssl_rx_frame_decoder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hssl_rx_frame_decoder.sv
// HSSL receive framing decoder: classifies 8b/10b words, tracks link sync from idles,
// strips SOF/EOF framing and emits payload words one word late so last is known.
module hssl_rx_frame_decoder #(
  parameter int unsigned SYNC_CNT   = 16,
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned ERR_WINDOW = 256,
  parameter int unsigned MAX_PLD    = 8
) (
  input  logic        clk_in,
  input  logic        resetn_in,
  input  logic [31:0] rx_data_in,
  input  logic [3:0]  rx_charisk_in,
  input  logic [3:0]  rx_disperr_in,
  input  logic [3:0]  rx_encerr_in,
  input  logic        rx_reset_done_in,
  output logic [31:0] pkt_data_out,
  output logic        pkt_vld_out,
  output logic        pkt_last_out,
  output logic        pkt_err_out,
  output logic        link_up_out,
  output logic [15:0] frame_cnt_out,
  output logic [15:0] err_cnt_out
);

  localparam logic       SyncLos   = 1'b0;
  localparam logic       SyncUp    = 1'b1;

  localparam logic [1:0] FrIdle    = 2'd0;
  localparam logic [1:0] FrPld     = 2'd1;
  localparam logic [1:0] FrDiscard = 2'd2;

  localparam logic [7:0]  SyncLast = 8'(SYNC_CNT - 1);
  localparam logic [3:0]  ErrLast  = 4'(ERR_THRESH - 1);
  localparam logic [15:0] WinLast  = 16'(ERR_WINDOW - 1);
  localparam logic [7:0]  PldMax   = 8'(MAX_PLD);

  localparam logic [7:0] KIdle = 8'hBC;
  localparam logic [7:0] KSof  = 8'hFB;
  localparam logic [7:0] KEof  = 8'hFD;

  // Word classification
  logic word_err, k_ctl;
  logic is_idle, is_sof, is_eof, is_data, is_bad;

  always_comb begin
    word_err = (|rx_disperr_in) | (|rx_encerr_in);
    k_ctl    = (rx_charisk_in == 4'b0001);
    is_idle  = !word_err && k_ctl && (rx_data_in[7:0] == KIdle);
    is_sof   = !word_err && k_ctl && (rx_data_in[7:0] == KSof);
    is_eof   = !word_err && k_ctl && (rx_data_in[7:0] == KEof);
    is_data  = !word_err && (rx_charisk_in == 4'b0000);
    is_bad   = !(is_idle || is_sof || is_eof || is_data);
  end

  // Sync FSM
  logic        sync_q, sync_d;
  logic [7:0]  idle_cnt_q, idle_cnt_d;
  logic [3:0]  win_err_q, win_err_d;
  logic [15:0] good_run_q, good_run_d;
  logic        link_up, link_drop;

  always_comb begin
    sync_d     = sync_q;
    idle_cnt_d = idle_cnt_q;
    win_err_d  = win_err_q;
    good_run_d = good_run_q;
    if (!rx_reset_done_in) begin
      sync_d     = SyncLos;
      idle_cnt_d = '0;
      win_err_d  = '0;
      good_run_d = '0;
    end else if (sync_q == SyncLos) begin
      if (is_idle) begin
        if (idle_cnt_q == SyncLast) begin
          sync_d     = SyncUp;
          idle_cnt_d = '0;
          win_err_d  = '0;
          good_run_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end else begin
        idle_cnt_d = '0;
      end
    end else if (is_bad) begin
      good_run_d = '0;
      if (win_err_q == ErrLast) begin
        sync_d     = SyncLos;
        win_err_d  = '0;
        idle_cnt_d = '0;
      end else begin
        win_err_d = win_err_q + 4'd1;
      end
    end else if (good_run_q == WinLast) begin
      good_run_d = '0;
      win_err_d  = '0;
    end else begin
      good_run_d = good_run_q + 16'd1;
    end
  end

  assign link_up   = (sync_q == SyncUp);
  // Flush the held word on the same edge that link_up_out falls.
  assign link_drop = link_up && (sync_d == SyncLos);

  // Frame FSM with a one-word holding register
  logic [1:0]  fr_q, fr_d;
  logic [7:0]  pld_cnt_q, pld_cnt_d;
  logic        held_vld_q, held_vld_d;
  logic [31:0] held_data_q, held_data_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        emit, emit_last, emit_err;

  always_comb begin
    fr_d        = fr_q;
    pld_cnt_d   = pld_cnt_q;
    held_vld_d  = held_vld_q;
    held_data_d = held_data_q;
    frame_cnt_d = frame_cnt_q;
    emit        = 1'b0;
    emit_last   = 1'b0;
    emit_err    = 1'b0;
    if (link_drop) begin
      emit       = held_vld_q;
      emit_last  = 1'b1;
      emit_err   = 1'b1;
      held_vld_d = 1'b0;
      pld_cnt_d  = '0;
      fr_d       = FrIdle;
    end else if (link_up) begin
      unique case (fr_q)
        FrIdle, FrDiscard: begin
          if (is_sof) begin
            fr_d      = FrPld;
            pld_cnt_d = '0;
          end
        end
        FrPld: begin
          if (is_data) begin
            if (pld_cnt_q == PldMax) begin
              emit       = 1'b1;
              emit_last  = 1'b1;
              emit_err   = 1'b1;
              held_vld_d = 1'b0;
              pld_cnt_d  = '0;
              fr_d       = FrDiscard;
            end else begin
              emit        = held_vld_q;
              held_vld_d  = 1'b1;
              held_data_d = rx_data_in;
              pld_cnt_d   = pld_cnt_q + 8'd1;
            end
          end else if (is_eof) begin
            emit       = held_vld_q;
            emit_last  = 1'b1;
            held_vld_d = 1'b0;
            pld_cnt_d  = '0;
            fr_d       = FrIdle;
            if (held_vld_q) begin
              frame_cnt_d = frame_cnt_q + 16'd1;
            end
          end else begin
            emit       = held_vld_q;
            emit_last  = 1'b1;
            emit_err   = 1'b1;
            held_vld_d = 1'b0;
            pld_cnt_d  = '0;
            fr_d       = is_sof ? FrPld : FrDiscard;
          end
        end
        default: fr_d = FrIdle;
      endcase
    end
  end

  // Output and statistics registers
  logic [31:0] pkt_data_q, pkt_data_d;
  logic        pkt_vld_q, pkt_last_q, pkt_err_q;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    pkt_data_d = emit ? held_data_q : pkt_data_q;
    err_cnt_d  = err_cnt_q;
    if (rx_reset_done_in && is_bad && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      sync_q      <= SyncLos;
      idle_cnt_q  <= '0;
      win_err_q   <= '0;
      good_run_q  <= '0;
      fr_q        <= FrIdle;
      pld_cnt_q   <= '0;
      held_vld_q  <= 1'b0;
      held_data_q <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      pkt_data_q  <= '0;
      pkt_vld_q   <= 1'b0;
      pkt_last_q  <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      idle_cnt_q  <= idle_cnt_d;
      win_err_q   <= win_err_d;
      good_run_q  <= good_run_d;
      fr_q        <= fr_d;
      pld_cnt_q   <= pld_cnt_d;
      held_vld_q  <= held_vld_d;
      held_data_q <= held_data_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      pkt_data_q  <= pkt_data_d;
      pkt_vld_q   <= emit;
      pkt_last_q  <= emit & emit_last;
      pkt_err_q   <= emit & emit_err;
    end
  end

  assign pkt_data_out  = pkt_data_q;
  assign pkt_vld_out   = pkt_vld_q;
  assign pkt_last_out  = pkt_last_q;
  assign pkt_err_out   = pkt_err_q;
  assign link_up_out   = link_up;
  assign frame_cnt_out = frame_cnt_q;
  assign err_cnt_out   = err_cnt_q;

endmodule

// File: tb/tb_hssl_rx_frame_decoder.sv
// Bench for hssl_rx_frame_decoder: directed scenarios plus random traffic against a
// frame-level reference model; outputs compared every cycle on the falling edge.
module tb_hssl_rx_frame_decoder;

  localparam int unsigned SYNC_CNT   = 16;
  localparam int unsigned ERR_THRESH = 4;
  localparam int unsigned ERR_WINDOW = 256;
  localparam int unsigned MAX_PLD    = 8;

  localparam int C_BAD = 0, C_IDLE = 1, C_SOF = 2, C_EOF = 3, C_DATA = 4;

  logic        clk_in = 1'b0;
  logic        resetn_in = 1'b0;
  logic [31:0] rx_data_in = 32'h0000_00BC;
  logic [3:0]  rx_charisk_in = 4'b0001;
  logic [3:0]  rx_disperr_in = 4'b0000;
  logic [3:0]  rx_encerr_in = 4'b0000;
  logic        rx_reset_done_in = 1'b1;
  logic [31:0] pkt_data_out;
  logic        pkt_vld_out, pkt_last_out, pkt_err_out, link_up_out;
  logic [15:0] frame_cnt_out, err_cnt_out;

  always #5 clk_in = ~clk_in;

  hssl_rx_frame_decoder #(
    .SYNC_CNT  (SYNC_CNT),
    .ERR_THRESH(ERR_THRESH),
    .ERR_WINDOW(ERR_WINDOW),
    .MAX_PLD   (MAX_PLD)
  ) dut (
    .clk_in          (clk_in),
    .resetn_in       (resetn_in),
    .rx_data_in      (rx_data_in),
    .rx_charisk_in   (rx_charisk_in),
    .rx_disperr_in   (rx_disperr_in),
    .rx_encerr_in    (rx_encerr_in),
    .rx_reset_done_in(rx_reset_done_in),
    .pkt_data_out    (pkt_data_out),
    .pkt_vld_out     (pkt_vld_out),
    .pkt_last_out    (pkt_last_out),
    .pkt_err_out     (pkt_err_out),
    .link_up_out     (link_up_out),
    .frame_cnt_out   (frame_cnt_out),
    .err_cnt_out     (err_cnt_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: link flag, run counters, and the payload words of the open frame.
  bit          m_up;
  int          idle_run, win_bad, good_run;
  logic [15:0] m_frames, m_errs;
  logic [31:0] frm[$];
  bit          in_frame;
  bit          e_vld, e_last, e_err;
  logic [31:0] e_data;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        e;
  } rec_t;
  rec_t got[$];

  function automatic int cls_of(input logic [31:0] d, input logic [3:0] k,
                                input logic [3:0] de, input logic [3:0] en);
    if (de != 0 || en != 0) return C_BAD;
    if (k == 4'b0000) return C_DATA;
    if (k != 4'b0001) return C_BAD;
    if (d[7:0] == 8'hBC) return C_IDLE;
    if (d[7:0] == 8'hFB) return C_SOF;
    if (d[7:0] == 8'hFD) return C_EOF;
    return C_BAD;
  endfunction

  task automatic emit(input logic [31:0] d, input bit l, input bit e);
    e_vld = 1'b1; e_data = d; e_last = l; e_err = e;
  endtask

  task automatic model_reset();
    m_up = 0; idle_run = 0; win_bad = 0; good_run = 0;
    m_frames = '0; m_errs = '0; frm.delete(); in_frame = 0;
    e_vld = 0; e_last = 0; e_err = 0; e_data = '0;
  endtask

  task automatic model_step(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de,
                            input logic [3:0] en, input logic done);
    int c;
    bit up_now, nxt;
    c = cls_of(d, k, de, en);
    up_now = m_up;
    nxt = up_now;
    e_vld = 0; e_last = 0; e_err = 0;
    if (done && c == C_BAD && m_errs != 16'hFFFF) m_errs++;
    if (!done) begin
      nxt = 0; idle_run = 0; win_bad = 0; good_run = 0;
    end else if (!up_now) begin
      if (c == C_IDLE) begin
        idle_run++;
        if (idle_run == SYNC_CNT) begin
          nxt = 1; idle_run = 0; win_bad = 0; good_run = 0;
        end
      end else begin
        idle_run = 0;
      end
    end else if (c == C_BAD) begin
      good_run = 0;
      win_bad++;
      if (win_bad == ERR_THRESH) begin
        nxt = 0; win_bad = 0; idle_run = 0;
      end
    end else begin
      good_run++;
      if (good_run == ERR_WINDOW) begin
        good_run = 0; win_bad = 0;
      end
    end
    if (up_now && !nxt) begin
      if (frm.size() > 0) emit(frm[$], 1, 1);
      frm.delete(); in_frame = 0;
    end else if (up_now) begin
      if (c == C_SOF) begin
        if (in_frame && frm.size() > 0) emit(frm[$], 1, 1);
        frm.delete(); in_frame = 1;
      end else if (in_frame) begin
        case (c)
          C_DATA: begin
            if (frm.size() == MAX_PLD) begin
              emit(frm[$], 1, 1); frm.delete(); in_frame = 0;
            end else begin
              if (frm.size() > 0) emit(frm[$], 0, 0);
              frm.push_back(d);
            end
          end
          C_EOF: begin
            if (frm.size() > 0) begin
              emit(frm[$], 1, 0); m_frames++;
            end
            frm.delete(); in_frame = 0;
          end
          default: begin
            if (frm.size() > 0) emit(frm[$], 1, 1);
            frm.delete(); in_frame = 0;
          end
        endcase
      end
    end
    m_up = nxt;
  endtask

  // Compare process
  always @(negedge clk_in) begin
    chk("vld", pkt_vld_out, e_vld);
    if (e_vld && pkt_vld_out) begin
      chk("data", pkt_data_out, e_data);
      chk("last", pkt_last_out, e_last);
      chk("err", pkt_err_out, e_err);
    end
    chk("link_up", link_up_out, m_up);
    chk("frame_cnt", frame_cnt_out, m_frames);
    chk("err_cnt", err_cnt_out, m_errs);
    if (pkt_vld_out) got.push_back('{d: pkt_data_out, l: pkt_last_out, e: pkt_err_out});
  end

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de,
                      input logic [3:0] en, input logic done);
    rx_data_in = d; rx_charisk_in = k; rx_disperr_in = de; rx_encerr_in = en;
    rx_reset_done_in = done;
    @(posedge clk_in);
    model_step(d, k, de, en, done);
    @(negedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(32'h0000_00BC, 4'b0001, 4'b0, 4'b0, 1'b1);
  endtask
  task automatic sof();  send(32'h0000_00FB, 4'b0001, 4'b0, 4'b0, 1'b1); endtask
  task automatic eof();  send(32'h0000_00FD, 4'b0001, 4'b0, 4'b0, 1'b1); endtask
  task automatic data(input logic [31:0] d); send(d, 4'b0000, 4'b0, 4'b0, 1'b1); endtask
  task automatic bad();  send(32'h0000_00BC, 4'b0001, 4'b0010, 4'b0, 1'b1); endtask

  task automatic chk_rec(input string name, input int idx, input logic [31:0] d,
                         input logic l, input logic e);
    if (idx >= got.size()) begin
      chk({name, "_missing"}, 32'(got.size()), 32'(idx + 1));
    end else begin
      chk({name, "_d"}, got[idx].d, d);
      chk({name, "_l"}, got[idx].l, l);
      chk({name, "_e"}, got[idx].e, e);
    end
  endtask

  task automatic do_reset();
    rx_data_in = 32'h0000_00BC; rx_charisk_in = 4'b0001;
    rx_disperr_in = '0; rx_encerr_in = '0; rx_reset_done_in = 1'b1;
    resetn_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_in);
    #2 resetn_in = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk_in);
    #2 resetn_in = 1'b1;
    chk("rst_link", link_up_out, 1'b0);
    chk("rst_vld", pkt_vld_out, 1'b0);
    chk("rst_frames", frame_cnt_out, 16'd0);
    chk("rst_errs", err_cnt_out, 16'd0);

    // Sync acquisition, interrupted once by a DATA word
    idle(15); data(32'h1234_5678); idle(15);
    chk("sync_pre", link_up_out, 1'b0);
    idle(1);
    chk("sync_post", link_up_out, 1'b1);

    // Good frame
    got.delete();
    sof(); data(32'h1111_1111); data(32'h2222_2222); data(32'h3333_3333); eof(); idle(2);
    chk("gf_n", 32'(got.size()), 32'd3);
    chk_rec("gf0", 0, 32'h1111_1111, 1'b0, 1'b0);
    chk_rec("gf1", 1, 32'h2222_2222, 1'b0, 1'b0);
    chk_rec("gf2", 2, 32'h3333_3333, 1'b1, 1'b0);
    chk("gf_frames", frame_cnt_out, 16'd1);

    // Error-driven drop, then errors spread beyond the window
    for (int i = 0; i < 4; i++) begin
      bad();
      if (i < 3) idle(10);
    end
    chk("drop_link", link_up_out, 1'b0);
    chk("drop_errs", err_cnt_out, 16'd4);
    idle(16);
    chk("resync", link_up_out, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bad(); idle(300);
    end
    chk("window_link", link_up_out, 1'b1);
    chk("window_errs", err_cnt_out, 16'd8);

    // Oversize frame
    got.delete();
    sof();
    for (int i = 0; i < 9; i++) data(32'hA000_0000 + 32'(i));
    eof(); idle(2);
    chk("ovr_n", 32'(got.size()), 32'd8);
    chk_rec("ovr6", 6, 32'hA000_0006, 1'b0, 1'b0);
    chk_rec("ovr7", 7, 32'hA000_0007, 1'b1, 1'b1);
    chk("ovr_frames", frame_cnt_out, 16'd1);

    // Abort and restart, then an empty frame
    got.delete();
    sof(); data(32'hAAAA_AAAA); sof(); data(32'hBBBB_BBBB); eof(); idle(2);
    chk("abt_n", 32'(got.size()), 32'd2);
    chk_rec("abt0", 0, 32'hAAAA_AAAA, 1'b1, 1'b1);
    chk_rec("abt1", 1, 32'hBBBB_BBBB, 1'b1, 1'b0);
    chk("abt_frames", frame_cnt_out, 16'd2);
    got.delete();
    sof(); eof(); idle(2);
    chk("empty_n", 32'(got.size()), 32'd0);

    // GT reset mid-frame
    got.delete();
    sof(); data(32'hC1C1_C1C1); data(32'hC2C2_C2C2);
    send(32'h0000_00BC, 4'b0001, 4'b0, 4'b0, 1'b0);
    chk("gtr_link", link_up_out, 1'b0);
    chk("gtr_n", 32'(got.size()), 32'd2);
    chk_rec("gtr0", 0, 32'hC1C1_C1C1, 1'b0, 1'b0);
    chk_rec("gtr1", 1, 32'hC2C2_C2C2, 1'b1, 1'b1);
    idle(16);
    chk("gtr_resync", link_up_out, 1'b1);

    // Asynchronous reset between clock edges
    sof(); data(32'hD1D1_D1D1); data(32'hD2D2_D2D2);
    resetn_in = 1'b0;
    #1;
    chk("arst_link", link_up_out, 1'b0);
    chk("arst_vld", pkt_vld_out, 1'b0);
    chk("arst_frames", frame_cnt_out, 16'd0);
    chk("arst_errs", err_cnt_out, 16'd0);
    do_reset();

    // Random traffic
    for (int seg = 0; seg < 400; seg++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        int len;
        len = $urandom_range(0, 10);
        sof();
        for (int j = 0; j < len; j++) begin
          if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 2))
              0: bad();
              1: idle(1);
              default: sof();
            endcase
          end
          data($urandom);
        end
        if ($urandom_range(0, 9) != 0) eof();
      end else if (r == 5) begin
        idle($urandom_range(1, 5));
      end else if (r == 6) begin
        case ($urandom_range(0, 3))
          0: send($urandom, 4'b0000, 4'b0001, 4'b0, 1'b1);
          1: send($urandom, 4'b0001, 4'b0, 4'b1000, 1'b1);
          2: send(32'h0000_00BC, 4'b0011, 4'b0, 4'b0, 1'b1);
          default: send(32'h0000_001C, 4'b0001, 4'b0, 4'b0, 1'b1);
        endcase
      end else if (r == 7) begin
        send($urandom, 4'($urandom_range(0, 15)), 4'b0, 4'b0, 1'b1);
      end else if (r == 8) begin
        int n;
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) send($urandom, 4'b0001, 4'b0, 4'b0, 1'b0);
        idle(20);
      end else begin
        idle(20);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
